// File: rtl/rib_rr_arbiter_pkg.sv
// Shared RIB definitions for the arbiter slice.
// Holds the RIB field widths, the lock state encoding, and the one-hot and
// round-robin helper functions, so other RIB blocks can reuse them.
// Helpers work on an 8-bit master vector; callers pass their real master
// count so that bits above it are ignored.
package rib_rr_arbiter_pkg;

  localparam int RIB_AW = 32;
  localparam int RIB_DW = 32;
  localparam int RIB_MW = 4;
  localparam int RIB_MAX_MASTERS = 8;

  typedef enum logic {
    LOCK_OPEN = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

  // One-hot decode of a master index.
  function automatic logic [RIB_MAX_MASTERS-1:0] rib_onehot(input logic [2:0] id);
    rib_onehot = 8'b1 << id;
  endfunction

  // Round-robin pick: scans ptr, ptr+1, ... modulo n and returns
  // {found, index} of the first set request bit. The scan runs from the
  // far end back towards ptr so that the closest hit is written last.
  function automatic logic [3:0] rib_rr_pick(input logic [7:0] req,
                                             input logic [2:0] ptr,
                                             input int         n);
    logic [3:0] res;
    int         idx;
    res = 4'b0;
    for (int i = RIB_MAX_MASTERS - 1; i >= 0; i--) begin
      if (i < n) begin
        idx = int'(ptr) + i;
        if (idx >= n) idx = idx - n;
        if (req[idx]) res = {1'b1, idx[2:0]};
      end
    end
    rib_rr_pick = res;
  endfunction

endpackage

// File: rtl/rib_id_fifo.sv
// Granted-ID queue: synchronous FIFO of master indices.
// Ports:
//   i_clk, i_rstn  clock, asynchronous active-low reset (discards contents)
//   push, push_id  enqueue push_id (ignored when full)
//   pop            dequeue the head (ignored when empty)
//   head           oldest queued ID
//   full, empty    occupancy flags
//   count          number of queued IDs
module rib_id_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     push,
  input  logic [W-1:0]             push_id,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int CW = $clog2(DEPTH) + 1;
  // Pointer width is kept at least one bit so DEPTH=1 still elaborates.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/rib_rr_arbiter.sv
// Round-robin arbiter sharing one RIB slave port between MASTERS masters.
// Address phase is combinational: the round-robin winner (or the locked
// master while a request waits for the slave grant) drives the slave fields,
// and the slave grant passes straight back to that master. Every handshake
// pushes the winner's index into an ID queue; data-phase responses are
// steered to the master at the head of that queue.
// Handshake semantics: an address transfer happens in a cycle where
// o_ribs_req & i_ribs_gnt; a response transfer happens in a cycle where
// i_ribs_rsp & o_ribs_rdy. Masters hold req until gnt.
// Ports:
//   i_clk, i_rstn                 clock, asynchronous active-low reset
//   i_ribm_*  / o_ribm_*          per-master RIB ports (packed, master 0 in LSBs)
//   o_ribs_*  / i_ribs_*          shared slave RIB port
//   o_outstanding                 number of queued transaction IDs
//   o_err                         sticky: slave response with nothing queued
module rib_rr_arbiter
  import rib_rr_arbiter_pkg::*;
#(
  parameter int MASTERS     = 4,
  parameter int OUTSTANDING = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rstn,
  input  logic [RIB_AW*MASTERS-1:0]     i_ribm_addr,
  input  logic [MASTERS-1:0]            i_ribm_wrcs,
  input  logic [RIB_MW*MASTERS-1:0]     i_ribm_mask,
  input  logic [RIB_DW*MASTERS-1:0]     i_ribm_wdata,
  output logic [RIB_DW*MASTERS-1:0]     o_ribm_rdata,
  input  logic [MASTERS-1:0]            i_ribm_req,
  output logic [MASTERS-1:0]            o_ribm_gnt,
  output logic [MASTERS-1:0]            o_ribm_rsp,
  input  logic [MASTERS-1:0]            i_ribm_rdy,
  output logic [RIB_AW-1:0]             o_ribs_addr,
  output logic                          o_ribs_wrcs,
  output logic [RIB_MW-1:0]             o_ribs_mask,
  output logic [RIB_DW-1:0]             o_ribs_wdata,
  input  logic [RIB_DW-1:0]             i_ribs_rdata,
  output logic                          o_ribs_req,
  input  logic                          i_ribs_gnt,
  input  logic                          i_ribs_rsp,
  output logic                          o_ribs_rdy,
  output logic [$clog2(OUTSTANDING):0]  o_outstanding,
  output logic                          o_err
);

  localparam int IDW = $clog2(MASTERS);

  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] lock_id_q;
  logic [IDW-1:0] lock_id_d;
  lock_state_e    lock_q;
  lock_state_e    lock_d;
  logic [3:0]     pick;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] head;
  logic           any_req;
  logic           lock_live;
  logic           full;
  logic           empty;
  logic           hs;
  logic           pop;
  logic           err_q;

  // ---------------------------------------------------------------------
  // Winner selection
  // ---------------------------------------------------------------------
  assign any_req = |i_ribm_req;
  assign pick    = rib_rr_pick(8'(i_ribm_req), 3'(ptr_q), MASTERS);

  // A lock only holds while its master still requests; if that master drops
  // req the round-robin choice takes over in the same cycle.
  assign lock_live = (lock_q == LOCK_HELD) & i_ribm_req[lock_id_q];

  // With no request the scan finds nothing and the winner defaults to
  // master 0, which is also the master whose fields the slave sees.
  assign winner = lock_live ? lock_id_q : (pick[3] ? IDW'(pick[2:0]) : '0);

  // ---------------------------------------------------------------------
  // Address phase
  // ---------------------------------------------------------------------
  assign o_ribs_req   = any_req & ~full;
  assign hs           = o_ribs_req & i_ribs_gnt;
  assign o_ribs_addr  = i_ribm_addr [winner*RIB_AW +: RIB_AW];
  assign o_ribs_wrcs  = i_ribm_wrcs [winner];
  assign o_ribs_mask  = i_ribm_mask [winner*RIB_MW +: RIB_MW];
  assign o_ribs_wdata = i_ribm_wdata[winner*RIB_DW +: RIB_DW];

  always_comb begin
    o_ribm_gnt = '0;
    o_ribm_rsp = '0;
    for (int k = 0; k < MASTERS; k++) begin
      o_ribm_gnt[k] = hs & (winner == IDW'(k));
      o_ribm_rsp[k] = i_ribs_rsp & ~empty & (head == IDW'(k));
    end
  end

  // ---------------------------------------------------------------------
  // Lock state machine
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      lock_q    <= LOCK_OPEN;
      lock_id_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (hs) begin
      lock_d = LOCK_OPEN;
    end else if (o_ribs_req) begin
      // Request presented but not granted: pin the current winner.
      lock_d    = LOCK_HELD;
      lock_id_d = winner;
    end else if ((lock_q == LOCK_HELD) && !i_ribm_req[lock_id_q]) begin
      lock_d = LOCK_OPEN;
    end
  end

  // ---------------------------------------------------------------------
  // Round-robin pointer: the master just granted goes to lowest priority.
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ptr_q <= '0;
    end else if (hs) begin
      ptr_q <= (winner == IDW'(MASTERS - 1)) ? '0 : winner + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // ID queue and response routing
  // ---------------------------------------------------------------------
  rib_id_fifo #(
    .W     (IDW),
    .DEPTH (OUTSTANDING)
  ) u_id_fifo (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .push    (hs),
    .push_id (winner),
    .pop     (pop),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .count   (o_outstanding)
  );

  assign o_ribs_rdy   = ~empty & i_ribm_rdy[head];
  assign pop          = i_ribs_rsp & o_ribs_rdy;
  assign o_ribm_rdata = {MASTERS{i_ribs_rdata}};

  // Sticky error for a response that no queued transaction can own.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      err_q <= 1'b0;
    end else if (i_ribs_rsp && empty) begin
      err_q <= 1'b1;
    end
  end

  assign o_err = err_q;

endmodule

// File: tb/tb_rib_rr_arbiter.sv
module tb_rib_rr_arbiter;

  localparam int M    = 4;
  localparam int OUTS = 2;

  logic            i_clk;
  logic            i_rstn;
  logic [32*M-1:0] i_ribm_addr;
  logic [M-1:0]    i_ribm_wrcs;
  logic [4*M-1:0]  i_ribm_mask;
  logic [32*M-1:0] i_ribm_wdata;
  logic [32*M-1:0] o_ribm_rdata;
  logic [M-1:0]    i_ribm_req;
  logic [M-1:0]    o_ribm_gnt;
  logic [M-1:0]    o_ribm_rsp;
  logic [M-1:0]    i_ribm_rdy;
  logic [31:0]     o_ribs_addr;
  logic            o_ribs_wrcs;
  logic [3:0]      o_ribs_mask;
  logic [31:0]     o_ribs_wdata;
  logic [31:0]     i_ribs_rdata;
  logic            o_ribs_req;
  logic            i_ribs_gnt;
  logic            i_ribs_rsp;
  logic            o_ribs_rdy;
  logic [1:0]      o_outstanding;
  logic            o_err;

  rib_rr_arbiter #(.MASTERS(M), .OUTSTANDING(OUTS)) dut (
    .i_clk         (i_clk),
    .i_rstn        (i_rstn),
    .i_ribm_addr   (i_ribm_addr),
    .i_ribm_wrcs   (i_ribm_wrcs),
    .i_ribm_mask   (i_ribm_mask),
    .i_ribm_wdata  (i_ribm_wdata),
    .o_ribm_rdata  (o_ribm_rdata),
    .i_ribm_req    (i_ribm_req),
    .o_ribm_gnt    (o_ribm_gnt),
    .o_ribm_rsp    (o_ribm_rsp),
    .i_ribm_rdy    (i_ribm_rdy),
    .o_ribs_addr   (o_ribs_addr),
    .o_ribs_wrcs   (o_ribs_wrcs),
    .o_ribs_mask   (o_ribs_mask),
    .o_ribs_wdata  (o_ribs_wdata),
    .i_ribs_rdata  (i_ribs_rdata),
    .o_ribs_req    (o_ribs_req),
    .i_ribs_gnt    (i_ribs_gnt),
    .i_ribs_rsp    (i_ribs_rsp),
    .o_ribs_rdy    (o_ribs_rdy),
    .o_outstanding (o_outstanding),
    .o_err         (o_err)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(input int k);
    addr_of = 32'hA000_0000 + 32'(k * 16);
  endfunction

  task automatic set_const_fields();
    for (int k = 0; k < M; k++) begin
      i_ribm_addr [k*32 +: 32] = addr_of(k);
      i_ribm_wrcs [k]          = k[0];
      i_ribm_mask [k*4 +: 4]   = 4'(1 << k);
      i_ribm_wdata[k*32 +: 32] = 32'hD000_0000 + 32'(k);
    end
    i_ribs_rdata = 32'h1234_5678;
  endtask

  task automatic drive(input logic [3:0] req, input logic sgnt,
                       input logic srsp, input logic [3:0] rdy);
    i_ribm_req = req;
    i_ribs_gnt = sgnt;
    i_ribs_rsp = srsp;
    i_ribm_rdy = rdy;
  endtask

  task automatic next_cyc();
    @(posedge i_clk);
    #1;
  endtask

  // Leaves the bench at rising edge + 1 with reset released.
  task automatic do_reset();
    i_rstn = 1'b0;
    drive(4'h0, 1'b0, 1'b0, 4'h0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
  endtask

  // table vectors
  typedef struct {
    logic [3:0]  req;
    logic        sgnt;
    logic        srsp;
    logic [3:0]  rdy;
    logic        e_sreq;
    logic [3:0]  e_gnt;
    logic [3:0]  e_rsp;
    logic        e_srdy;
    logic [1:0]  e_out;
    logic [31:0] e_addr;
  } vec_t;

  vec_t tbl[7];

  // reference model
  int          m_q[$];
  int          m_ptr;
  bit          m_lock;
  int          m_lid;
  bit          m_err;
  logic [3:0]  req_hold;

  task automatic model_reset();
    m_q.delete();
    m_ptr  = 0;
    m_lock = 0;
    m_lid  = 0;
    m_err  = 0;
  endtask

  // Checks the DUT against the model for the current inputs, then advances
  // the model as the clock edge will advance the DUT. Returns the grant.
  task automatic model_cycle(output logic [3:0] granted);
    int w;
    bit any, full, hs;
    logic [3:0] e_gnt, e_rsp;
    logic e_rdy;
    any  = (i_ribm_req != 0);
    full = (m_q.size() == OUTS);
    w = 0;
    if (m_lock && i_ribm_req[m_lid]) begin
      w = m_lid;
    end else begin
      for (int i = M - 1; i >= 0; i--)
        if (i_ribm_req[(m_ptr + i) % M]) w = (m_ptr + i) % M;
    end
    hs    = any && !full && i_ribs_gnt;
    e_gnt = hs ? 4'(1 << w) : 4'h0;
    e_rsp = (i_ribs_rsp && m_q.size() > 0) ? 4'(1 << m_q[0]) : 4'h0;
    e_rdy = (m_q.size() > 0) && i_ribm_rdy[m_q[0]];
    chk("rnd_sreq",  o_ribs_req,    any && !full);
    chk("rnd_gnt",   o_ribm_gnt,    e_gnt);
    chk("rnd_rsp",   o_ribm_rsp,    e_rsp);
    chk("rnd_srdy",  o_ribs_rdy,    e_rdy);
    chk("rnd_out",   o_outstanding, m_q.size());
    chk("rnd_err",   o_err,         m_err);
    chk("rnd_addr",  o_ribs_addr,   i_ribm_addr[w*32 +: 32]);
    chk("rnd_wrcs",  o_ribs_wrcs,   i_ribm_wrcs[w]);
    chk("rnd_mask",  o_ribs_mask,   i_ribm_mask[w*4 +: 4]);
    chk("rnd_wdata", o_ribs_wdata,  i_ribm_wdata[w*32 +: 32]);
    chk("rnd_rdata", o_ribm_rdata[(w*32) +: 32] ^ o_ribm_rdata[0 +: 32], 64'(0));
    chk("rnd_rdata0", o_ribm_rdata[0 +: 32], i_ribs_rdata);
    // state advance
    if (i_ribs_rsp && m_q.size() == 0) m_err = 1;
    if (i_ribs_rsp && e_rdy) void'(m_q.pop_front());
    if (hs) begin
      m_q.push_back(w);
      m_ptr  = (w + 1) % M;
      m_lock = 0;
    end else if (any && !full) begin
      m_lock = 1;
      m_lid  = w;
    end else if (m_lock && !i_ribm_req[m_lid]) begin
      m_lock = 0;
    end
    granted = e_gnt;
  endtask

  logic [3:0] g;

  initial begin
    set_const_fields();
    do_reset();

    // reset state
    #2;
    chk("rst_out",  o_outstanding, 2'd0);
    chk("rst_err",  o_err,         1'b0);
    chk("rst_gnt",  o_ribm_gnt,    4'h0);
    chk("rst_rsp",  o_ribm_rsp,    4'h0);
    chk("rst_srdy", o_ribs_rdy,    1'b0);
    chk("rst_sreq", o_ribs_req,    1'b0);

    // fair rotation table
    tbl[0] = '{4'hF, 1'b1, 1'b0, 4'hF, 1'b1, 4'b0001, 4'b0000, 1'b0, 2'd0, addr_of(0)};
    tbl[1] = '{4'hF, 1'b1, 1'b1, 4'hF, 1'b1, 4'b0010, 4'b0001, 1'b1, 2'd1, addr_of(1)};
    tbl[2] = '{4'hF, 1'b1, 1'b1, 4'hF, 1'b1, 4'b0100, 4'b0010, 1'b1, 2'd1, addr_of(2)};
    tbl[3] = '{4'hF, 1'b1, 1'b1, 4'hF, 1'b1, 4'b1000, 4'b0100, 1'b1, 2'd1, addr_of(3)};
    tbl[4] = '{4'hF, 1'b1, 1'b1, 4'hF, 1'b1, 4'b0001, 4'b1000, 1'b1, 2'd1, addr_of(0)};
    tbl[5] = '{4'h0, 1'b0, 1'b1, 4'hF, 1'b0, 4'b0000, 4'b0001, 1'b1, 2'd1, addr_of(0)};
    tbl[6] = '{4'h0, 1'b0, 1'b0, 4'hF, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, addr_of(0)};
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].req, tbl[i].sgnt, tbl[i].srsp, tbl[i].rdy);
      #2;
      chk($sformatf("tbl%0d_sreq", i), o_ribs_req,    tbl[i].e_sreq);
      chk($sformatf("tbl%0d_gnt",  i), o_ribm_gnt,    tbl[i].e_gnt);
      chk($sformatf("tbl%0d_rsp",  i), o_ribm_rsp,    tbl[i].e_rsp);
      chk($sformatf("tbl%0d_srdy", i), o_ribs_rdy,    tbl[i].e_srdy);
      chk($sformatf("tbl%0d_out",  i), o_outstanding, tbl[i].e_out);
      chk($sformatf("tbl%0d_addr", i), o_ribs_addr,   tbl[i].e_addr);
      next_cyc();
    end
    chk("tbl_err", o_err, 1'b0);

    // lock hold, then full queue with and without a same-cycle pop
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(4'b0110, 1'b0, 1'b0, 4'h0);
      #2;
      chk($sformatf("lock%0d_addr", c), o_ribs_addr, addr_of(1));
      chk($sformatf("lock%0d_sreq", c), o_ribs_req,  1'b1);
      chk($sformatf("lock%0d_gnt",  c), o_ribm_gnt,  4'h0);
      next_cyc();
    end
    drive(4'b1110, 1'b0, 1'b0, 4'h0); #2;
    chk("lock_m3_addr", o_ribs_addr, addr_of(1));
    next_cyc();
    drive(4'b1111, 1'b0, 1'b0, 4'h0); #2;
    chk("lock_m0_addr", o_ribs_addr, addr_of(1));
    next_cyc();
    drive(4'b1111, 1'b1, 1'b0, 4'h0); #2;
    chk("lock_gnt", o_ribm_gnt, 4'b0010);
    next_cyc();
    drive(4'b1101, 1'b1, 1'b0, 4'h0); #2;
    chk("lock_ptr2_gnt", o_ribm_gnt, 4'b0100);
    next_cyc();
    drive(4'b1001, 1'b1, 1'b0, 4'h0); #2;
    chk("full_out",  o_outstanding, 2'd2);
    chk("full_sreq", o_ribs_req,    1'b0);
    chk("full_gnt",  o_ribm_gnt,    4'h0);
    next_cyc();
    drive(4'b1001, 1'b1, 1'b1, 4'hF); #2;
    chk("fullpop_sreq", o_ribs_req, 1'b0);
    chk("fullpop_gnt",  o_ribm_gnt, 4'h0);
    chk("fullpop_rsp",  o_ribm_rsp, 4'b0010);
    chk("fullpop_srdy", o_ribs_rdy, 1'b1);
    next_cyc();
    drive(4'h0, 1'b0, 1'b0, 4'h0); #2;
    chk("fullpop_out", o_outstanding, 2'd1);

    // locked master withdrawing its request
    do_reset();
    drive(4'b0110, 1'b0, 1'b0, 4'h0); #2;
    chk("wd_addr1", o_ribs_addr, addr_of(1));
    next_cyc();
    drive(4'b0100, 1'b0, 1'b0, 4'h0); #2;
    chk("wd_addr2", o_ribs_addr, addr_of(2));
    chk("wd_sreq",  o_ribs_req,  1'b1);
    next_cyc();

    // out-of-order ready, with pointer wrap 3 -> 0
    do_reset();
    drive(4'b0100, 1'b1, 1'b0, 4'h0); #2;
    chk("ooo_gnt2", o_ribm_gnt, 4'b0100);
    next_cyc();
    drive(4'b0001, 1'b1, 1'b0, 4'h0); #2;
    chk("ooo_gnt0_wrap", o_ribm_gnt, 4'b0001);
    next_cyc();
    drive(4'h0, 1'b0, 1'b1, 4'b1011); #2;
    chk("ooo_hold_out",  o_outstanding, 2'd2);
    chk("ooo_hold_rsp",  o_ribm_rsp,    4'b0100);
    chk("ooo_hold_srdy", o_ribs_rdy,    1'b0);
    next_cyc();
    drive(4'h0, 1'b0, 1'b1, 4'b0100); #2;
    chk("ooo_nopop_out", o_outstanding, 2'd2);
    chk("ooo_pop2_rsp",  o_ribm_rsp,    4'b0100);
    chk("ooo_pop2_srdy", o_ribs_rdy,    1'b1);
    next_cyc();
    drive(4'h0, 1'b0, 1'b1, 4'b0001); #2;
    chk("ooo_head0_rsp", o_ribm_rsp,    4'b0001);
    chk("ooo_head0_out", o_outstanding, 2'd1);
    chk("ooo_head0_srdy", o_ribs_rdy,   1'b1);
    next_cyc();
    drive(4'h0, 1'b0, 1'b0, 4'h0); #2;
    chk("ooo_empty_out", o_outstanding, 2'd0);
    chk("ooo_err",       o_err,         1'b0);

    // stray response and reset mid-transaction
    do_reset();
    drive(4'h0, 1'b0, 1'b1, 4'hF); #2;
    chk("stray_rsp",  o_ribm_rsp, 4'h0);
    chk("stray_srdy", o_ribs_rdy, 1'b0);
    next_cyc();
    drive(4'b0010, 1'b1, 1'b0, 4'h0); #2;
    chk("stray_err",  o_err,      1'b1);
    chk("stray_gnt1", o_ribm_gnt, 4'b0010);
    next_cyc();
    drive(4'h0, 1'b0, 1'b0, 4'hF); #2;
    chk("mid_out", o_outstanding, 2'd1);
    chk("mid_srdy", o_ribs_rdy,   1'b1);
    i_rstn = 1'b0;
    #1;
    chk("mid_rst_out",  o_outstanding, 2'd0);
    chk("mid_rst_err",  o_err,         1'b0);
    chk("mid_rst_srdy", o_ribs_rdy,    1'b0);
    next_cyc();
    i_rstn = 1'b1;
    drive(4'h0, 1'b0, 1'b1, 4'hF); #2;
    chk("post_rst_rsp", o_ribm_rsp, 4'h0);
    next_cyc();
    drive(4'hF, 1'b1, 1'b0, 4'h0); #2;
    chk("post_rst_err",  o_err,      1'b1);
    chk("post_rst_ptr0", o_ribm_gnt, 4'b0001);
    next_cyc();

    // randomized traffic against the reference model
    do_reset();
    model_reset();
    req_hold = 4'h0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int k = 0; k < M; k++) begin
        if (!req_hold[k] && $urandom_range(0, 2) == 0) req_hold[k] = 1'b1;
        i_ribm_addr [k*32 +: 32] = $urandom;
        i_ribm_wrcs [k]          = 1'($urandom_range(0, 1));
        i_ribm_mask [k*4 +: 4]   = 4'($urandom_range(0, 15));
        i_ribm_wdata[k*32 +: 32] = $urandom;
      end
      i_ribs_rdata = $urandom;
      drive(req_hold, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0),
            4'($urandom_range(0, 15)));
      #2;
      model_cycle(g);
      req_hold = req_hold & ~g;
      next_cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end

endmodule
